sqrt_iter: RTL and testbench
============================

# sqrt_iter

Multi-cycle, parametrised integer square-root unit with valid/ready handshakes on both sides. It computes the floor root and the remainder of an unsigned radical of any width using a restoring digit-by-digit algorithm, resolving a configurable number of root bits per clock. It sits in the image-match datapath as the next-generation root engine, with backpressure-aware streaming between the distance accumulator (upstream) and the score normaliser (downstream).

## Interface
- WIDTH, 16, radical width in bits, ≥1
- STEPS, 1, root bits resolved per clock, 1..QW; QW must be a multiple of STEPS
- Derived: QW = (WIDTH+1)/2 (root width); RW = QW+1 (remainder width); N = QW/STEPS (iteration count)
- clk  in  1  clock, rising edge
- aclr  in  1  asynchronous clear, active-high
- ena  in  1  clock enable; low freezes all state, outputs held
- in_valid  in  1  radical valid
- in_ready  out  1  unit can accept a radical
- radical  in  WIDTH  unsigned operand
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- q  out  QW  root (floor, or rounded when SQRT_ROUND_EN is defined)
- remainder  out  RW  radical − floor_root², always from the floor root
- busy  out  1  high in RUN

## Operation
- States: IDLE, RUN, DONE. Reset state IDLE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Accept = in_valid & in_ready & ena.
- On accept: radical is zero-extended to 2·QW bits and latched; partial root, partial remainder and iteration counter are cleared; go to RUN.
- RUN, per enabled edge: STEPS iterations of the restoring algorithm. Each iteration does r' = (r<<2) | next two radical bits (MSB pair first), then t = (root<<2)|1. If r' ≥ t: r = r' − t and root = (root<<1)|1; otherwise r = r' and root = root<<1. The counter increments. After iteration N: go to DONE and load q/remainder.
- Arithmetic: internal remainder register is RW+1 bits wide. The compare is unsigned at full width, so no truncation occurs before the compare.
- DONE: out_valid=1; q and remainder hold stable while out_ready=0. When out_ready=1 the next state is IDLE, or RUN if a new radical is accepted on the same edge.
- out_valid is high only in DONE. q and remainder keep their last values outside DONE.
- in_valid while not in_ready: ignored. The upstream holds its data per standard valid/ready.
- ena=0: no state, counter or output changes. Handshakes do not complete.

## Timing
- Latency: out_valid rises on the Nth enabled edge after the accept edge (WIDTH=16, STEPS=1: 8 edges; STEPS=2: 4 edges).
- Throughput with out_ready held high: one result per N+1 edges (back-to-back accept in DONE).
- aclr asserted, at any time including mid-RUN: state IDLE, out_valid=0, busy=0, q=0, remainder=0, in_ready=1 (after aclr deasserts). Any in-flight operation is discarded with no partial result.
- Reset values: in_ready=1, out_valid=0, busy=0, q=0, remainder=0.
- WIDTH odd: the radical is zero-extended at the MSB, so the first bit pair is {0, radical[WIDTH-1]}.

## Configuration
- SQRT_ROUND_EN defined: q = floor_root + 1 when remainder > floor_root (round-to-nearest; ties are impossible for integers), saturating at 2^QW−1. This costs one extra compare/increment, registered into q in the DONE-load cycle, with no added latency.
- Undefined: q = floor_root.
- remainder is identical in both builds.

## Test plan
- WIDTH=16, STEPS=1, radical=0xFFFF, out_ready=1 → out_valid 8 edges after accept, q=255, remainder=510. With SQRT_ROUND_EN: q=255 (saturated).
- radical=24 → q=4, remainder=8 (SQRT_ROUND_EN: q=5). radical=20 → q=4, remainder=4 (q=4 in both builds). radical=0 → q=0, remainder=0.
- WIDTH=7, STEPS=1, radical=127 → QW=4, q=11, remainder=6, latency 4. WIDTH=16, STEPS=2, radical=1000 → q=31, remainder=39, latency 4.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → q and remainder stable, in_ready=0. Then raise out_ready with in_valid=1 → the result is consumed and the new radical is accepted on the same edge.
- aclr pulsed at iteration 3 of 8 → all outputs go to reset values immediately. The next operation, radical=49, returns q=7, remainder=0.
- ena=0 for 3 cycles mid-RUN → latency extends by exactly 3 edges and the result is unchanged.

Source files
------------

// File: rtl/sqrt_iter.sv
// Multi-cycle restoring square-root unit with valid/ready handshakes on both sides.
// Optional build macro SQRT_ROUND_EN rounds q to nearest; remainder is always from the floor root.
module sqrt_iter #(
    parameter int WIDTH = 16,
    parameter int STEPS = 1,
    localparam int QW = (WIDTH + 1) / 2,
    localparam int RW = QW + 1
) (
    input  logic          clk,
    input  logic          aclr,
    input  logic          ena,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WIDTH-1:0] radical,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [QW-1:0] q,
    output logic [RW-1:0] remainder,
    output logic          busy
);

    localparam int N  = QW / STEPS;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_n;
    logic [2*QW-1:0] rad_reg, rad_n;
    logic [QW-1:0]   root_reg, root_n;
    logic [RW:0]     rem_reg, rem_n;
    logic [RW:0]     rem_sh, trial;
    logic [CW-1:0]   cnt;
    logic [QW-1:0]   q_load;
    logic            accept, last;

    assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
    assign accept    = in_valid && in_ready && ena;
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN);
    assign last      = (cnt == CW'(N - 1));

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = RUN;
            RUN:     if (last) state_n = DONE;
            DONE:    if (out_ready) state_n = accept ? RUN : IDLE;
            default: state_n = IDLE;
        endcase
    end

    // STEPS restoring iterations unrolled into one clock; the remainder is kept one bit
    // wider than RW so the shifted value never truncates before the compare.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        rad_n  = rad_reg;
        root_n = root_reg;
        rem_n  = rem_reg;
        rem_sh = '0;
        trial  = '0;
        for (int i = 0; i < STEPS; i++) begin
            rem_sh = {rem_n[RW-2:0], rad_n[2*QW-1 -: 2]};
            trial  = {root_n, 2'b01};
            rad_n  = rad_n << 2;
            if (rem_sh >= trial) begin
                rem_n  = rem_sh - trial;
                root_n = (root_n << 1) | QW'(1);
            end else begin
                rem_n  = rem_sh;
                root_n = root_n << 1;
            end
        end
    end

`ifdef SQRT_ROUND_EN
    always_comb begin
        q_load = root_n;
        if (rem_n[RW-1:0] > {1'b0, root_n} && !(&root_n))
            q_load = root_n + QW'(1);
    end
`else
    assign q_load = root_n;
`endif

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state     <= IDLE;
            rad_reg   <= '0;
            root_reg  <= '0;
            rem_reg   <= '0;
            cnt       <= '0;
            q         <= '0;
            remainder <= '0;
        end else if (ena) begin
            state <= state_n;
            if (accept) begin
                rad_reg  <= (2*QW)'(radical);
                root_reg <= '0;
                rem_reg  <= '0;
                cnt      <= '0;
            end else if (state == RUN) begin
                rad_reg  <= rad_n;
                root_reg <= root_n;
                rem_reg  <= rem_n;
                cnt      <= cnt + CW'(1);
                if (last) begin
                    q         <= q_load;
                    remainder <= rem_n[RW-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_sqrt_iter.sv
// Directed bench for sqrt_iter: WIDTH=16/STEPS=1, WIDTH=7/STEPS=1 and WIDTH=16/STEPS=2 instances.
// Expected roots are hand-computed for both SQRT_ROUND_EN builds.
module tb_sqrt_iter;

`ifdef SQRT_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic clk = 1'b0;
    logic aclr = 1'b1;
    logic ena = 1'b1;
    logic out_ready = 1'b1;
    logic in_valid_c = 1'b0;
    logic [15:0] rad_c = '0;
    logic [1:0] sel = 2'd0;

    logic in_valid0, in_ready0, out_valid0, busy0;
    logic [7:0] q0;
    logic [8:0] rem0;
    logic in_valid7, in_ready7, out_valid7, busy7;
    logic [3:0] q7;
    logic [4:0] rem7;
    logic in_valid2, in_ready2, out_valid2, busy2;
    logic [7:0] q2;
    logic [8:0] rem2;

    logic rdy, ov, bsy;
    logic [15:0] q_o, rem_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign in_valid0 = in_valid_c && (sel == 2'd0);
    assign in_valid7 = in_valid_c && (sel == 2'd1);
    assign in_valid2 = in_valid_c && (sel == 2'd2);

    sqrt_iter #(.WIDTH(16), .STEPS(1)) dut (
        .clk(clk), .aclr(aclr), .ena(ena), .in_valid(in_valid0), .in_ready(in_ready0),
        .radical(rad_c), .out_valid(out_valid0), .out_ready(out_ready),
        .q(q0), .remainder(rem0), .busy(busy0));

    sqrt_iter #(.WIDTH(7), .STEPS(1)) dut7 (
        .clk(clk), .aclr(aclr), .ena(ena), .in_valid(in_valid7), .in_ready(in_ready7),
        .radical(rad_c[6:0]), .out_valid(out_valid7), .out_ready(out_ready),
        .q(q7), .remainder(rem7), .busy(busy7));

    sqrt_iter #(.WIDTH(16), .STEPS(2)) dut2 (
        .clk(clk), .aclr(aclr), .ena(ena), .in_valid(in_valid2), .in_ready(in_ready2),
        .radical(rad_c), .out_valid(out_valid2), .out_ready(out_ready),
        .q(q2), .remainder(rem2), .busy(busy2));

    always_comb begin
        rdy = in_ready0; ov = out_valid0; bsy = busy0;
        q_o = 16'(q0); rem_o = 16'(rem0);
        case (sel)
            2'd1: begin
                rdy = in_ready7; ov = out_valid7; bsy = busy7;
                q_o = 16'(q7); rem_o = 16'(rem7);
            end
            2'd2: begin
                rdy = in_ready2; ov = out_valid2; bsy = busy2;
                q_o = 16'(q2); rem_o = 16'(rem2);
            end
            default: ;
        endcase
    end

    function automatic logic [15:0] pick(input logic [15:0] fl, input logic [15:0] rn);
        return RND ? rn : fl;
    endfunction

    // Presents one radical and returns at the negedge following its accept edge.
    task automatic start(input logic [15:0] rad, input string name);
        @(negedge clk);
        rad_c = rad;
        in_valid_c = 1'b1;
        #1;
        n_vec++;
        if (rdy !== 1'b1) begin
            n_err++;
            $display("FAIL %s in_ready: got %b want 1", name, rdy);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid_c = 1'b0;
    endtask

    // Called at a negedge after the accept edge; counts further edges until out_valid.
    task automatic wait_result(input logic [15:0] eq, input logic [15:0] er,
                               input int el, input string name);
        int lat = 0;
        while (!ov && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        n_vec++;
        if (ov !== 1'b1) begin
            n_err++;
            $display("FAIL %s timeout: out_valid never rose", name);
        end
        n_vec++;
        if (lat !== el) begin
            n_err++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, el);
        end
        n_vec++;
        if (q_o !== eq) begin
            n_err++;
            $display("FAIL %s q: got %0d want %0d", name, q_o, eq);
        end
        n_vec++;
        if (rem_o !== er) begin
            n_err++;
            $display("FAIL %s remainder: got %0d want %0d", name, rem_o, er);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        n_vec++;
        if ({rdy, ov, bsy} !== 3'b100 || q_o !== 16'd0 || rem_o !== 16'd0) begin
            n_err++;
            $display("FAIL %s: got rdy=%b ov=%b busy=%b q=%0d rem=%0d want 1 0 0 0 0",
                     name, rdy, ov, bsy, q_o, rem_o);
        end
    endtask

    task automatic test_reset();
        sel = 2'd0;
        #1 check_idle_outputs("reset_dut16");
        sel = 2'd1;
        #1 check_idle_outputs("reset_dut7");
        sel = 2'd2;
        #1 check_idle_outputs("reset_dut16s2");
        sel = 2'd0;
        @(negedge clk);
        aclr = 1'b0;
    endtask

    task automatic test_basic();
        sel = 2'd0;
        out_ready = 1'b1;
        start(16'hFFFF, "ffff");  wait_result(pick(255, 255), 510, 8, "ffff");
        start(16'd24, "r24");     wait_result(pick(4, 5), 8, 8, "r24");
        start(16'd20, "r20");     wait_result(pick(4, 4), 4, 8, "r20");
        start(16'd0, "r0");       wait_result(pick(0, 0), 0, 8, "r0");
        start(16'd15, "r15");     wait_result(pick(3, 4), 6, 8, "r15");
        start(16'd2, "r2");       wait_result(pick(1, 1), 1, 8, "r2");
        @(negedge clk);
        n_vec++;
        if (ov !== 1'b0) begin
            n_err++;
            $display("FAIL basic_drain out_valid: got %b want 0", ov);
        end
    endtask

    task automatic test_width7();
        sel = 2'd1;
        start(16'd127, "w7_127"); wait_result(pick(11, 11), 6, 4, "w7_127");
        start(16'd1, "w7_1");     wait_result(pick(1, 1), 0, 4, "w7_1");
        @(negedge clk);
        sel = 2'd0;
    endtask

    task automatic test_steps2();
        sel = 2'd2;
        start(16'd1000, "s2_1000"); wait_result(pick(31, 32), 39, 4, "s2_1000");
        start(16'hFFFF, "s2_ffff"); wait_result(pick(255, 255), 510, 4, "s2_ffff");
        @(negedge clk);
        sel = 2'd0;
    endtask

    task automatic test_backpressure();
        sel = 2'd0;
        out_ready = 1'b0;
        start(16'd24, "bp");
        wait_result(pick(4, 5), 8, 8, "bp");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_vec++;
            if (ov !== 1'b1 || rdy !== 1'b0 || q_o !== pick(4, 5) || rem_o !== 16'd8) begin
                n_err++;
                $display("FAIL bp_hold%0d: got ov=%b rdy=%b q=%0d rem=%0d want 1 0 %0d 8",
                         i, ov, rdy, q_o, rem_o, pick(4, 5));
            end
        end
        rad_c = 16'd20;
        in_valid_c = 1'b1;
        out_ready = 1'b1;
        #1;
        n_vec++;
        if (rdy !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release in_ready: got %b want 1", rdy);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid_c = 1'b0;
        n_vec++;
        if (ov !== 1'b0 || bsy !== 1'b1) begin
            n_err++;
            $display("FAIL bp_same_edge: got ov=%b busy=%b want 0 1", ov, bsy);
        end
        wait_result(pick(4, 4), 4, 8, "bp_next");
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        sel = 2'd0;
        out_ready = 1'b1;
        start(16'd24, "b2b_first");
        rad_c = 16'd49;
        in_valid_c = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (ov !== 1'b1 || rdy !== 1'b1 || q_o !== pick(4, 5) || rem_o !== 16'd8) begin
            n_err++;
            $display("FAIL b2b_done: got ov=%b rdy=%b q=%0d rem=%0d want 1 1 %0d 8",
                     ov, rdy, q_o, rem_o, pick(4, 5));
        end
        @(posedge clk);
        @(negedge clk);
        in_valid_c = 1'b0;
        n_vec++;
        if (bsy !== 1'b1 || ov !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_accept: got busy=%b ov=%b want 1 0", bsy, ov);
        end
        wait_result(pick(7, 7), 0, 8, "b2b_second");
        @(negedge clk);
    endtask

    task automatic test_aclr_mid_run();
        sel = 2'd0;
        start(16'hFFFF, "aclr_run");
        repeat (3) @(posedge clk);
        @(negedge clk);
        aclr = 1'b1;
        #1 check_idle_outputs("aclr_mid_run");
        @(negedge clk);
        aclr = 1'b0;
        #1 check_idle_outputs("aclr_released");
        start(16'd49, "aclr_next");
        wait_result(pick(7, 7), 0, 8, "aclr_next");
        @(negedge clk);
    endtask

    task automatic test_ena_freeze();
        sel = 2'd0;
        start(16'd1000, "ena");
        repeat (2) @(posedge clk);
        @(negedge clk);
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_vec++;
            if (bsy !== 1'b1 || ov !== 1'b0) begin
                n_err++;
                $display("FAIL ena_freeze%0d: got busy=%b ov=%b want 1 0", i, bsy, ov);
            end
        end
        ena = 1'b1;
        // Total edges after accept must be 8 + 3 = 11; five have already elapsed.
        wait_result(pick(31, 32), 39, 11 - 5, "ena_resume");
        @(negedge clk);
        ena = 1'b0;
        rad_c = 16'd4;
        in_valid_c = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_c = 1'b0;
        ena = 1'b1;
        n_vec++;
        if (bsy !== 1'b0 || ov !== 1'b0) begin
            n_err++;
            $display("FAIL ena_no_accept: got busy=%b ov=%b want 0 0", bsy, ov);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_width7();
        test_steps2();
        test_backpressure();
        test_back_to_back();
        test_aclr_mid_run();
        test_ena_freeze();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
